// File: rtl/vga_sync_decoder.sv
// Sink-side VGA sync decoder: rebuilds x/y, display enable and frame start from
// hsync_n/vsync_n, checks line/frame timing and tracks lock over clean frames.
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        hsync_n,
  input  logic        vsync_n,
  input  logic        clear_errors,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        display_enable,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error,
  output logic [3:0]  err_status
);
  localparam logic [15:0] H_TOTAL = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_LOAD  = 16'(H_VISIBLE + H_FP);
  localparam logic [15:0] V_LOAD  = 16'(V_VISIBLE + V_FP);
  localparam logic [15:0] H_VIS   = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS   = 16'(V_VISIBLE);
  localparam logic [15:0] H_SW    = 16'(H_SYNC);
  localparam logic [15:0] V_SW    = 16'(V_SYNC);
  localparam logic [15:0] LOSS_LIMIT = 16'(2 * (H_VISIBLE + H_FP + H_SYNC + H_BP));
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] h_per_q, h_per_d, h_low_q, h_low_d, loss_q, loss_d;
  logic [15:0] v_lines_q, v_lines_d, v_low_q, v_low_d;
  logic        h_armed_q, h_armed_d, hw_armed_q, hw_armed_d;
  logic        v_armed_q, v_armed_d, vw_armed_q, vw_armed_d;
  logic        frame_bad_q, frame_bad_d;
  logic [7:0]  good_q, good_d;
  logic [3:0]  err_q, err_d;
  logic        de_q, fs_q, te_q, locked_q;

  logic h_edge, v_edge, h_rise, v_rise;
  logic h_period_bad, h_width_bad, v_bad, loss_bad, any_err, unlock;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign h_edge = hs_prev_q & ~hsync_n;
  assign v_edge = vs_prev_q & ~vsync_n;
  assign h_rise = ~hs_prev_q & hsync_n;
  assign v_rise = ~vs_prev_q & vsync_n;

  assign h_period_bad = h_edge & h_armed_q & (h_per_q != H_TOTAL - 16'd1);
  assign h_width_bad  = h_rise & hw_armed_q & (h_low_q != H_SW);
  assign v_bad = (v_edge & v_armed_q & ((v_lines_q + {15'd0, h_edge}) != V_TOTAL))
               | (v_rise & vw_armed_q & (v_low_q != V_SW));
  assign loss_bad = h_armed_q & ~h_edge & (loss_q == LOSS_LIMIT - 16'd1);
  assign any_err  = h_period_bad | h_width_bad | v_bad | loss_bad;

  always_comb begin
    x_d = h_edge ? H_LOAD : ((x_q == H_TOTAL - 16'd1) ? 16'd0 : x_q + 16'd1);
    y_d = y_q;
    if (v_edge)
      y_d = V_LOAD;
    else if (!h_edge && x_q == H_TOTAL - 16'd1)
      y_d = (y_q == V_TOTAL - 16'd1) ? 16'd0 : y_q + 16'd1;

    h_per_d   = h_edge ? 16'd0 : sat_inc(h_per_q);
    h_low_d   = h_edge ? 16'd1 : (!hsync_n ? sat_inc(h_low_q) : h_low_q);
    loss_d    = h_edge ? 16'd0 : ((loss_q == LOSS_LIMIT) ? loss_q : loss_q + 16'd1);
    // The closing V edge's coincident H edge belongs to the frame it closes.
    v_lines_d = v_edge ? 16'd0 : (h_edge ? sat_inc(v_lines_q) : v_lines_q);
    v_low_d   = v_edge ? {15'd0, h_edge} : ((!vsync_n && h_edge) ? sat_inc(v_low_q) : v_low_q);
    frame_bad_d = v_edge ? 1'b0 : (frame_bad_q | any_err);
    err_d = (clear_errors ? 4'd0 : err_q) | {loss_bad, v_bad, h_width_bad, h_period_bad};
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      UNLOCKED: if (v_edge) begin
        state_d = ACQUIRE;
        good_d  = 8'd0;
      end
      ACQUIRE: begin
        if (loss_bad) begin
          state_d = UNLOCKED;
          good_d  = 8'd0;
        end else if (any_err) begin
          good_d = 8'd0;
        end else if (v_edge && !frame_bad_q) begin
          if (good_q + 8'd1 == LOCK_N) begin
            state_d = LOCKED;
            good_d  = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      LOCKED: if (any_err) begin
        state_d = UNLOCKED;
        good_d  = 8'd0;
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = 8'd0;
      end
    endcase
  end

  // Losing lock disarms every check so the next edges only realign.
  assign unlock = (state_q != UNLOCKED) && (state_d == UNLOCKED);

  always_comb begin
    h_armed_d  = unlock ? 1'b0 : (h_armed_q | h_edge);
    hw_armed_d = unlock ? 1'b0 : (h_edge ? h_armed_q : hw_armed_q);
    v_armed_d  = unlock ? 1'b0 : (v_armed_q | v_edge);
    vw_armed_d = unlock ? 1'b0 : (v_edge ? v_armed_q : vw_armed_q);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      h_per_q     <= 16'd0;
      h_low_q     <= 16'd0;
      loss_q      <= 16'd0;
      v_lines_q   <= 16'd0;
      v_low_q     <= 16'd0;
      h_armed_q   <= 1'b0;
      hw_armed_q  <= 1'b0;
      v_armed_q   <= 1'b0;
      vw_armed_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      good_q      <= 8'd0;
      err_q       <= 4'd0;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      te_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hsync_n;
      vs_prev_q   <= vsync_n;
      x_q         <= x_d;
      y_q         <= y_d;
      h_per_q     <= h_per_d;
      h_low_q     <= h_low_d;
      loss_q      <= loss_d;
      v_lines_q   <= v_lines_d;
      v_low_q     <= v_low_d;
      h_armed_q   <= h_armed_d;
      hw_armed_q  <= hw_armed_d;
      v_armed_q   <= v_armed_d;
      vw_armed_q  <= vw_armed_d;
      frame_bad_q <= frame_bad_d;
      good_q      <= good_d;
      err_q       <= err_d;
      de_q        <= (x_d < H_VIS) && (y_d < V_VIS) && (state_d == LOCKED);
      fs_q        <= (x_d == 16'd0) && (y_d == 16'd0) && (state_d == LOCKED);
      te_q        <= any_err;
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign x_pos          = x_q;
  assign y_pos          = y_q;
  assign display_enable = de_q;
  assign frame_start    = fs_q;
  assign locked         = locked_q;
  assign timing_error   = te_q;
  assign err_status     = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a small-raster source model
// (same porch/sync structure as 640x480, short frames).
module tb_vga_sync_decoder;
  localparam int HV = 16, HFP = 4, HS = 6, HBP = 6, HT = HV + HFP + HS + HBP;
  localparam int VV = 12, VFP = 2, VS = 2, VBP = 4, VT = VV + VFP + VS + VBP;
  localparam int H_LOW = HV + HFP, V_LOW = VV + VFP;

  logic        clk = 1'b0;
  logic        reset = 1'b1, hsync_n = 1'b1, vsync_n = 1'b1, clear_errors = 1'b0;
  logic [15:0] x_pos, y_pos;
  logic        display_enable, frame_start, locked, timing_error;
  logic [3:0]  err_status;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .LOCK_FRAMES(2)
  ) dut (
    .clk_25MHz(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .clear_errors(clear_errors), .x_pos(x_pos), .y_pos(y_pos),
    .display_enable(display_enable), .frame_start(frame_start), .locked(locked),
    .timing_error(timing_error), .err_status(err_status)
  );

  typedef struct {
    int hx; int vy; int x; int y; bit de; bit fs;
  } probe_t;
  probe_t probes[10];

  int checks = 0, passed = 0;
  int hx = 0, vy = 0, last_hx = 0, last_vy = 0;
  int line_len = HT, hs_w = HS, frame_lines = VT;
  bit hs_off = 0, pend_long = 0, pend_narrow = 0, pend_short = 0, vs_drv_prev = 1;
  int vedges = 0, fs_cnt = 0, de_cnt = 0, te_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    hsync_n = (hs_off || !(hx >= H_LOW && hx < H_LOW + hs_w)) ? 1'b1 : 1'b0;
    vsync_n = (vy >= V_LOW && vy < V_LOW + VS) ? 1'b0 : 1'b1;
    if (vs_drv_prev && !vsync_n) vedges++;
    vs_drv_prev = vsync_n;
    @(posedge clk);
    #1;
    last_hx = hx;
    last_vy = vy;
    if (frame_start) fs_cnt++;
    if (display_enable) de_cnt++;
    if (timing_error) te_cnt++;
    hx++;
    if (hx >= line_len) begin
      hx = 0;
      vy++;
      if (vy >= frame_lines) begin
        vy = 0;
        frame_lines = pend_short ? VT - 1 : VT;
        pend_short = 0;
      end
      line_len = pend_long ? HT + 1 : HT;
      hs_w = pend_narrow ? HS - 1 : HS;
      pend_long = 0;
      pend_narrow = 0;
    end
  endtask

  task automatic wait_at(input int tx, input int ty, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(last_hx == tx && last_vy == ty) && n < budget);
    if (!(last_hx == tx && last_vy == ty)) begin
      checks++;
      $display("FAIL wait_at(%0d,%0d): timed out at (%0d,%0d)", tx, ty, last_hx, last_vy);
    end
  endtask

  task automatic wait_vedges(input int k, input int budget);
    int target = vedges + k;
    int n = 0;
    while (vedges < target && n < budget) begin
      step();
      n++;
    end
    if (vedges < target) begin
      checks++;
      $display("FAIL wait_vedges: got %0d edges required %0d", vedges, target);
    end
  endtask

  task automatic wait_te(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!timing_error && n < budget);
    check({name, "_timing_error"}, timing_error, 1);
  endtask

  task automatic clear_pulse(input string name);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    check({name, "_cleared"}, err_status, 0);
  endtask

  task automatic relock(input string name);
    wait_vedges(2, 1500);
    check({name, "_locked_after2"}, locked, 0);
    wait_vedges(1, 800);
    check({name, "_locked_after3"}, locked, 1);
    check({name, "_err_clean"}, err_status, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_x"}, x_pos, 0);
    check({name, "_y"}, y_pos, 0);
    check({name, "_de"}, display_enable, 0);
    check({name, "_fs"}, frame_start, 0);
    check({name, "_locked"}, locked, 0);
    check({name, "_te"}, timing_error, 0);
    check({name, "_err"}, err_status, 0);
  endtask

  initial begin
    probes[0] = '{hx: 0,  vy: 0,  x: 0,  y: 0,  de: 1, fs: 1};
    probes[1] = '{hx: 15, vy: 0,  x: 15, y: 0,  de: 1, fs: 0};
    probes[2] = '{hx: 16, vy: 0,  x: 16, y: 0,  de: 0, fs: 0};
    probes[3] = '{hx: 31, vy: 0,  x: 31, y: 0,  de: 0, fs: 0};
    probes[4] = '{hx: 0,  vy: 1,  x: 0,  y: 1,  de: 1, fs: 0};
    probes[5] = '{hx: 15, vy: 11, x: 15, y: 11, de: 1, fs: 0};
    probes[6] = '{hx: 16, vy: 11, x: 16, y: 11, de: 0, fs: 0};
    probes[7] = '{hx: 0,  vy: 12, x: 0,  y: 12, de: 0, fs: 0};
    probes[8] = '{hx: 20, vy: 14, x: 20, y: 14, de: 0, fs: 0};
    probes[9] = '{hx: 31, vy: 19, x: 31, y: 19, de: 0, fs: 0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    wait_at(H_LOW, 0, 100);
    check("first_hedge_x", x_pos, H_LOW);
    wait_vedges(2, 1500);
    check("init_locked_after2", locked, 0);
    wait_vedges(1, 800);
    check("init_locked_after3", locked, 1);
    check("init_err", err_status, 0);

    foreach (probes[i]) begin
      wait_at(probes[i].hx, probes[i].vy, 2 * HT * VT);
      check($sformatf("probe%0d_x", i), x_pos, probes[i].x);
      check($sformatf("probe%0d_y", i), y_pos, probes[i].y);
      check($sformatf("probe%0d_de", i), display_enable, probes[i].de);
      check($sformatf("probe%0d_fs", i), frame_start, probes[i].fs);
    end

    fs_cnt = 0;
    de_cnt = 0;
    repeat (HT * VT) step();
    check("frame_fs_count", fs_cnt, 1);
    check("frame_de_count", de_cnt, HV * VV);

    pend_long = 1;
    wait_te("long", 200);
    check("long_err", err_status, 4'b0001);
    check("long_locked", locked, 0);
    step();
    check("long_te_oneshot", timing_error, 0);
    clear_pulse("long");
    relock("long");

    pend_narrow = 1;
    wait_te("narrow", 200);
    check("narrow_err", err_status, 4'b0010);
    check("narrow_locked", locked, 0);
    clear_pulse("narrow");
    relock("narrow");

    pend_short = 1;
    wait_te("short", 2 * HT * VT + 100);
    check("short_err", err_status, 4'b0100);
    check("short_locked", locked, 0);
    clear_pulse("short");
    relock("short");

    wait_at(HT - 1, V_LOW + VS, 2 * HT * VT);
    hs_off = 1;
    wait_te("loss", 200);
    check("loss_err", err_status, 4'b1000);
    check("loss_locked", locked, 0);
    check("loss_fire_hx", last_hx, H_LOW);
    check("loss_fire_vy", last_vy, V_LOW + VS + 2);
    wait_at(HT - 1, VT - 1, 200);
    hs_off = 0;
    clear_pulse("loss");
    check("loss_wrap_x", x_pos, 0);
    check("loss_wrap_y", y_pos, 0);
    relock("loss");

    wait_at(5, 5, 2 * HT * VT);
    reset = 1'b1;
    #2;
    check_reset_outputs("midreset");
    repeat (3) step();
    reset = 1'b0;
    te_cnt = 0;
    wait_at(H_LOW, 5, 100);
    check("midreset_hedge_x", x_pos, H_LOW);
    relock("midreset");
    check("midreset_no_errors", te_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
